// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, keyboard command bytes and default timing.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      INHIBIT,
      WAIT_EDGE,
      WAIT_IDLE
   } tx_state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   // 120 us inhibit and 15 ms edge timeout at a 100 MHz system clock
   localparam int DEF_INHIBIT_CYCLES = 12000;
   localparam int DEF_TIMEOUT_CYCLES = 1500000;
   localparam int DEF_CNT_W          = 21;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and completion status between a PS/2 command issuer and the host transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       err;

   modport master (output tx_data, tx_valid, input tx_ready, busy, done, ack_ok, err);
   modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, ack_ok, err);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines plus falling-edge detect on the clock.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic clk_raw,
   input  logic data_raw,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic [1:0] clk_ff;
   logic [1:0] data_ff;
   logic       clk_prev;

   // Reset to the idle (released, high) level so leaving reset never fakes a falling edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_ff   <= 2'b11;
         data_ff  <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_ff   <= {clk_ff[0], clk_raw};
         data_ff  <= {data_ff[0], data_raw};
         clk_prev <= clk_ff[1];
      end
   end

   assign clk_sync  = clk_ff[1];
   assign data_sync = data_ff[1];
   assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard and reports the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   ps2_host_tx_if.slave bus,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

   localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX = '1;

   tx_state_t        state, state_n;
   logic [CNT_W-1:0] timer, timer_n;
   logic [3:0]       bitcnt, bitcnt_n;
   logic [8:0]       shift, shift_n;
   logic             clk_oe, clk_oe_n;
   logic             data_oe, data_oe_n;
   logic             ack_r, ack_r_n;
   logic             done_q, done_n;
   logic             ack_q, ack_n;
   logic             err_q, err_n;

   logic clk_s, data_s, clk_fall;

   ps2_line_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .clk_raw   (ps2_clk_in),
      .data_raw  (ps2_data_in),
      .clk_sync  (clk_s),
      .data_sync (data_s),
      .clk_fall  (clk_fall)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         timer   <= '0;
         bitcnt  <= '0;
         shift   <= '0;
         clk_oe  <= 1'b0;
         data_oe <= 1'b0;
         ack_r   <= 1'b0;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         bitcnt  <= bitcnt_n;
         shift   <= shift_n;
         clk_oe  <= clk_oe_n;
         data_oe <= data_oe_n;
         ack_r   <= ack_r_n;
         done_q  <= done_n;
         ack_q   <= ack_n;
         err_q   <= err_n;
      end
   end

   // Line enables are registered next-state values, so each bit changes one cycle after its device clock fall
   always_comb begin
      state_n   = state;
      timer_n   = (timer == TIMER_MAX) ? timer : timer + 1'b1;
      bitcnt_n  = bitcnt;
      shift_n   = shift;
      clk_oe_n  = clk_oe;
      data_oe_n = data_oe;
      ack_r_n   = ack_r;
      done_n    = 1'b0;
      ack_n     = 1'b0;
      err_n     = 1'b0;

      unique case (state)
         IDLE: begin
            timer_n   = '0;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (bus.tx_valid) begin
               shift_n  = {odd_parity(bus.tx_data), bus.tx_data};
               bitcnt_n = '0;
               clk_oe_n = 1'b1;
               state_n  = INHIBIT;
            end
         end

         INHIBIT: begin
            if (timer == INH_LAST) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b1;
               timer_n   = '0;
               state_n   = WAIT_EDGE;
            end
         end

         WAIT_EDGE: begin
            if (clk_fall) begin
               timer_n = '0;
               if (bitcnt <= 4'd8) begin
                  data_oe_n = ~shift[0];
                  shift_n   = {1'b0, shift[8:1]};
                  bitcnt_n  = bitcnt + 4'd1;
               end else if (bitcnt == 4'd9) begin
                  data_oe_n = 1'b0;
                  bitcnt_n  = 4'd10;
               end else begin
                  ack_r_n = ~data_s;
                  state_n = WAIT_IDLE;
               end
            end else if (timer == TO_LAST) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               done_n    = 1'b1;
               err_n     = 1'b1;
               state_n   = IDLE;
            end
         end

         WAIT_IDLE: begin
            if (clk_s && data_s) begin
               done_n  = 1'b1;
               ack_n   = ack_r;
               state_n = IDLE;
            end else if (timer == TO_LAST) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               done_n    = 1'b1;
               err_n     = 1'b1;
               state_n   = IDLE;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign bus.tx_ready = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.ack_ok   = ack_q;
   assign bus.err      = err_q;
   assign ps2_clk_oe   = clk_oe;
   assign ps2_data_oe  = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard on scaled-down timing.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 60;
   localparam int TO   = 400;
   localparam int CW   = 10;
   localparam int HALF = 20;
   localparam int DEV_NORMAL = 0;
   localparam int DEV_NOACK  = 1;
   localparam int DEV_SILENT = 2;

   typedef struct {
      logic       ack;
      logic       err;
      logic       chk_frame;
      logic [8:0] frame;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ps2_host_tx_if bus ();
   logic clk_oe, data_oe;
   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;
   logic ps2_clk_line, ps2_data_line;

   // Open-drain wired-AND of host and device pull-downs
   assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
   assign ps2_data_line = ~(data_oe | dev_data_low);

   exp_t       exp_q[$];
   int         cmp_count   = 0;
   int         fail_count  = 0;
   int         done_count  = 0;
   int         dev_mode    = DEV_NORMAL;
   logic       dev_abort   = 1'b0;
   int         dev_bit_cnt = 0;
   logic [8:0] dev_frame   = '0;
   logic       dev_stop    = 1'b0;
   int         inh_len     = 0;
   int         inh_run     = 0;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (clk_oe),
      .ps2_data_oe (data_oe)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      cmp_count++;
      if (act !== req) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            done_count++;
            check_output("done_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_output("ack_ok", 32'(bus.ack_ok), 32'(e.ack));
               check_output("err", 32'(bus.err), 32'(e.err));
               if (e.chk_frame) begin
                  check_output("frame_on_line", 32'(dev_frame), 32'(e.frame));
                  check_output("stop_bit", 32'(dev_stop), 1);
               end
            end
         end else if (bus.err !== 1'b0) begin
            check_output("err_without_done", 32'(bus.err), 0);
         end
      end
   end

   initial begin : inhibit_meter
      forever begin
         @(posedge clk);
         #1;
         if (clk_oe === 1'b1) inh_run++;
         else begin
            if (inh_run > 0) inh_len = inh_run;
            inh_run = 0;
         end
      end
   end

   task automatic dev_half();
      repeat (HALF) @(negedge clk);
   endtask

   // Keyboard side: 11 clock pulses, data read on each rising edge, ACK pulled low before the 11th fall
   task automatic dev_frame_run();
      logic [9:0] rx = '0;
      dev_bit_cnt = 0;
      for (int k = 1; k <= 11; k++) begin
         if (k == 11 && dev_mode == DEV_NORMAL) dev_data_low = 1'b1;
         dev_half();
         if (dev_abort) begin
            dev_data_low = 1'b0;
            return;
         end
         dev_clk_low = 1'b1;
         dev_half();
         dev_clk_low = 1'b0;
         if (dev_abort) begin
            dev_data_low = 1'b0;
            return;
         end
         if (k <= 10) begin
            rx[k-1]     = ps2_data_line;
            dev_bit_cnt = k;
         end
         if (k == 10) begin
            dev_frame = rx[8:0];
            dev_stop  = rx[9];
         end
      end
      dev_half();
      dev_data_low = 1'b0;
   endtask

   initial begin : device
      logic seen_inh = 1'b0;
      forever begin
         @(negedge clk);
         if (clk_oe === 1'b1) seen_inh = 1'b1;
         else if (seen_inh && data_oe === 1'b1) begin
            seen_inh = 1'b0;
            if (dev_mode != DEV_SILENT) dev_frame_run();
         end
      end
   end

   task automatic apply_stimulus(input logic [7:0] data, input logic push, input logic ack,
                                 input logic err, input logic chk, input logic [8:0] frame);
      int n = 0;
      @(negedge clk);
      while (bus.tx_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_output("tx_ready_before_send", 32'(bus.tx_ready), 1);
      bus.tx_data  = data;
      bus.tx_valid = 1'b1;
      if (push) exp_q.push_back('{ack, err, chk, frame});
      @(posedge clk);
      #1;
      check_output("tx_ready_after_accept", 32'(bus.tx_ready), 0);
      check_output("busy_after_accept", 32'(bus.busy), 1);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_count < target && n < 3000) begin
         @(posedge clk);
         #2;
         n++;
      end
      check_output("done_within_budget", 32'(done_count >= target), 1);
   endtask

   task automatic wait_dev_bits(input int bits);
      int n = 0;
      while (dev_bit_cnt < bits && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_output("device_reached_bit", 32'(dev_bit_cnt >= bits), 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int n;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_tx_ready", 32'(bus.tx_ready), 1);
      check_output("reset_busy", 32'(bus.busy), 0);
      check_output("reset_clk_oe", 32'(clk_oe), 0);
      check_output("reset_data_oe", 32'(data_oe), 0);
      check_output("reset_done", 32'(bus.done), 0);
      check_output("reset_ack_ok", 32'(bus.ack_ok), 0);
      check_output("reset_err", 32'(bus.err), 0);
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] set-LEDs 0xED with ACK");
      apply_stimulus(CMD_SET_LEDS, 1'b1, 1'b1, 1'b0, 1'b1, 9'h1ED);
      wait_done(1);
      check_output("inhibit_cycles", inh_len, INH);
      check_output("tx_ready_after_done", 32'(bus.tx_ready), 1);

      $display("[TB] parity cases 0x07 and 0x00");
      apply_stimulus(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 9'h007);
      wait_done(2);
      apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 9'h100);
      wait_done(3);

      $display("[TB] device withholds ACK");
      dev_mode = DEV_NOACK;
      apply_stimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1A5);
      wait_done(4);

      $display("[TB] device never clocks");
      dev_mode = DEV_SILENT;
      apply_stimulus(CMD_SET_LEDS, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
      n = 0;
      while (data_oe !== 1'b1 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("request_started", 32'(data_oe), 1);
      n = 0;
      while (bus.done !== 1'b1 && n < 2 * TO) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("timeout_cycles", n, TO);
      check_output("timeout_clk_oe", 32'(clk_oe), 0);
      check_output("timeout_data_oe", 32'(data_oe), 0);
      check_output("timeout_tx_ready", 32'(bus.tx_ready), 1);
      wait_done(5);

      $display("[TB] reset after bit 4, then 0xF4");
      dev_mode    = DEV_NORMAL;
      dev_bit_cnt = 0;
      apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
      wait_dev_bits(4);
      @(negedge clk);
      dev_abort = 1'b1;
      rst       = 1'b0;
      @(posedge clk);
      #1;
      check_output("midreset_clk_oe", 32'(clk_oe), 0);
      check_output("midreset_data_oe", 32'(data_oe), 0);
      check_output("midreset_tx_ready", 32'(bus.tx_ready), 1);
      check_output("midreset_done", 32'(bus.done), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (60) @(negedge clk);
      dev_abort = 1'b0;
      apply_stimulus(CMD_ENABLE, 1'b1, 1'b1, 1'b0, 1'b1, 9'h0F4);
      wait_done(6);

      $display("[TB] 0x55 request while busy");
      dev_bit_cnt = 0;
      apply_stimulus(CMD_RESET, 1'b1, 1'b1, 1'b0, 1'b1, 9'h1FF);
      wait_dev_bits(3);
      @(negedge clk);
      bus.tx_data  = 8'h55;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      check_output("tx_ready_while_busy", 32'(bus.tx_ready), 0);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      wait_done(7);
      repeat (1000) @(posedge clk);
      #1;
      check_output("leftover_expectations", exp_q.size(), 0);
      check_output("total_done_pulses", done_count, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 keyboard port; the counterpart of the keyboard receive path used by the operation encoder.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs to light the player indicators or 0xFF reset, and reports whether the device acknowledged it.
- Drives the open-drain PS2_CLK/PS2_DATA lines through active-high pull-low enables; the top level does the tristating: line = oe ? 1'b0 : 1'bz.

Parameters:
- INHIBIT_CYCLES, 12000, number of clk cycles ps2_clk is held low before the request (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, maximum number of clk cycles between expected device clock edges (15 ms).
- CNT_W, 21, width of the timing counter; must satisfy 2^CNT_W > max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to send; sampled on the accepting cycle.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high in IDLE only; a byte is accepted when tx_valid && tx_ready.
- ps2_clk_in  in  1  raw PS2_CLK line level (asynchronous).
- ps2_data_in  in  1  raw PS2_DATA line level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.
- busy  out  1  high in every state except IDLE; the receive path ignores the line while this is high.
- done  out  1  one-cycle pulse when a transfer ends, with or without error.
- ack_ok  out  1  valid while done is high; 1 = device ACK seen.
- err  out  1  one-cycle pulse, coincident with done, on timeout.

Behaviour:
- Synchronisation and edge detect
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - fall = previous synchronised clk is 1 and current synchronised clk is 0. This adds 3 cycles of latency, which is acceptable.
- Reset (rst == 0 on a rising clk)
  - State goes to IDLE.
  - oe outputs = 0, so both lines are released.
  - tx_ready = 1; busy = done = ack_ok = err = 0.
  - Counters and shift register are cleared.
  - A reset mid-frame releases both lines in the same cycle. No done pulse is produced.
- Frame
  - Shift register = {odd_parity, tx_data}, where odd_parity = ~^tx_data.
  - The start bit is the data line already held low. Bit order is LSB first.
- States
  - IDLE
    - On tx_valid: latch the shift register, set bitcnt = 0, clear the timer, go to INHIBIT.
  - INHIBIT
    - clk_oe = 1, data_oe = 0.
    - When the timer reaches INHIBIT_CYCLES-1: assert data_oe = 1, release clk_oe, clear the timer, go to WAIT_EDGE.
  - WAIT_EDGE
    - data_oe holds the current bit value: 1 when driving a 0 bit (start bit or a data/parity bit of 0).
    - On fall with bitcnt 0..8: data_oe = ~shift[0], shift right, bitcnt++, clear the timer.
    - On fall with bitcnt == 9: data_oe = 0 (stop bit, released), bitcnt = 10.
    - On fall with bitcnt == 10: sample the synchronised data. ack_ok_r = (data == 0). Go to WAIT_IDLE.
  - WAIT_IDLE
    - Wait until both synchronised lines are 1.
    - Then pulse done, set ack_ok = ack_ok_r, go to IDLE.
  - Timeout
    - Applies in WAIT_EDGE and WAIT_IDLE.
    - If the timer reaches TIMEOUT_CYCLES-1: release both lines, pulse done and err, set ack_ok = 0, go to IDLE.
- Other rules
  - tx_valid while busy is ignored; the request is not queued.
  - tx_ready is deasserted one cycle after acceptance.
  - done and tx_ready can be high in the same cycle only after done; the next accept is possible the cycle after done.
  - The timer saturates and does not wrap.
  - The device may hold clock low longer than one cycle. Only falls count as edges, and glitch-free input is assumed after the synchroniser.

Decomposition:
- Package ps2_pkg holds:
  - the state encoding IDLE/INHIBIT/WAIT_EDGE/WAIT_IDLE;
  - command constants CMD_SET_LEDS = 8'hED, CMD_RESET = 8'hFF, CMD_ENABLE = 8'hF4, RESP_ACK = 8'hFA;
  - the default timing constants.
- One sub-module, ps2_line_sync: 2-FF synchroniser plus falling-edge detect for clk/data. It is shared with the receive path.

Test Plan:
- Send 0xED; the device model clocks at 12.5 kHz and ACKs.
  - Inhibit lasts 12000 cycles.
  - Bits driven are 1,0,1,1,0,1,1,1 (LSB first), then parity 1, then stop released.
  - Response: done=1, ack_ok=1, err=0, tx_ready returns 1.
- Send 0x07: parity bit = 0 (data_oe=1 during the parity bit). Send 0x00: parity bit = 1. Both end with ack_ok=1.
- Device omits the ACK (data stays high on the 11th fall) -> done=1, ack_ok=0, err=0.
- Device never clocks after the request -> after 1500000 cycles: done=err=1, both oe=0, state IDLE.
- Assert rst=0 after bit 4 -> next cycle: both oe=0, tx_ready=1, no done pulse. A subsequent send of 0xF4 completes normally.
- Pulse tx_valid with 0x55 during an active transfer -> ignored. Only the original byte appears on the line, and there is exactly one done pulse.
